// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer.
// Time values are 14-bit milliseconds; the random delay offset is 10-bit.
package reaction_pkg;

  localparam int TIME_W           = 14;
  localparam int RAND_W           = 10;
  localparam int MIN_DELAY_MS_DEF = 1000;
  localparam int MAX_MS_DEF       = 9999;

  typedef enum logic [2:0] {
    HI_SCORE   = 3'b000,
    DELAYING   = 3'b001,
    TIMING     = 3'b010,
    DISPLAYING = 3'b011,
    GO_BUFFS   = 3'b100
  } state_e;

endpackage

// File: rtl/reaction_ctrl_key_edge.sv
// Two-flop synchronizer plus falling-edge detector for an active-low key.
// press_p is a one-clk pulse derived only from flops.
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_p
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = key_n;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign press_p = prev_q & ~s2_q;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer controller: random delay, reaction timing, high score.
// All outputs come straight from flops.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int MIN_DELAY_MS = MIN_DELAY_MS_DEF,
  parameter int MAX_MS       = MAX_MS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_1ms,
  input  logic              start_n,
  input  logic              react_n,
  input  logic              buffs_sw,
  input  logic [RAND_W-1:0] rand_delay,
  output logic              lfsr_en,
  output logic [2:0]        state,
  output logic [TIME_W-1:0] react_ms,
  output logic [TIME_W-1:0] hi_score,
  output logic              new_hi,
  output logic              cheat
);

  localparam logic [TIME_W-1:0] MAX_T  = TIME_W'(MAX_MS);
  localparam logic [TIME_W-1:0] MAX_M1 = TIME_W'(MAX_MS - 1);
  localparam logic [TIME_W-1:0] MIN_T  = TIME_W'(MIN_DELAY_MS);
  localparam logic [TIME_W-1:0] ONE_T  = TIME_W'(1);

  logic start_p;
  logic react_p;

  key_edge u_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (start_n),
    .press_p (start_p)
  );

  key_edge u_react (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (react_n),
    .press_p (react_p)
  );

  state_e            state_q, state_d;
  logic [TIME_W-1:0] dly_q, dly_d;
  logic [TIME_W-1:0] react_q, react_d;
  logic [TIME_W-1:0] hi_q, hi_d;
  logic              new_hi_q, new_hi_d;
  logic              cheat_q, cheat_d;
  logic              lfsr_en_q, lfsr_en_d;
  logic [TIME_W-1:0] dly_load;

  assign dly_load = MIN_T + TIME_W'(rand_delay);

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    react_d  = react_q;
    hi_d     = hi_q;
    cheat_d  = cheat_q;
    new_hi_d = 1'b0;
    if (buffs_sw) begin
      state_d = GO_BUFFS;
      dly_d   = '0;
    end else begin
      unique case (state_q)
        HI_SCORE: begin
          if (start_p) begin
            state_d = DELAYING;
            dly_d   = dly_load;
            react_d = '0;
            cheat_d = 1'b0;
          end
        end
        DELAYING: begin
          if (react_p) begin
            state_d = DISPLAYING;
            react_d = MAX_T;
            cheat_d = 1'b1;
          end else if (tick_1ms) begin
            if (dly_q <= ONE_T) begin
              state_d = TIMING;
              react_d = '0;
              dly_d   = '0;
            end else begin
              dly_d = dly_q - ONE_T;
            end
          end
        end
        TIMING: begin
          if (react_p) begin
            state_d = DISPLAYING;
          end else if (tick_1ms) begin
            // saturate at the timeout value and end the round there
            if (react_q >= MAX_M1) begin
              react_d = MAX_T;
              state_d = DISPLAYING;
            end else begin
              react_d = react_q + ONE_T;
            end
          end
        end
        DISPLAYING: begin
          if (react_p) begin
            state_d = HI_SCORE;
          end else if (start_p) begin
            state_d = DELAYING;
            dly_d   = dly_load;
            react_d = '0;
            cheat_d = 1'b0;
          end
        end
        GO_BUFFS: state_d = HI_SCORE;
        default:  state_d = HI_SCORE;
      endcase
      // score update lands on the edge that enters DISPLAYING
      if (state_d == DISPLAYING && state_q != DISPLAYING &&
          !cheat_d && react_d < hi_q) begin
        hi_d     = react_d;
        new_hi_d = 1'b1;
      end
    end
    lfsr_en_d = (state_d == HI_SCORE) || (state_d == DISPLAYING);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= HI_SCORE;
      dly_q     <= '0;
      react_q   <= '0;
      hi_q      <= MAX_T;
      new_hi_q  <= 1'b0;
      cheat_q   <= 1'b0;
      lfsr_en_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      react_q   <= react_d;
      hi_q      <= hi_d;
      new_hi_q  <= new_hi_d;
      cheat_q   <= cheat_d;
      lfsr_en_q <= lfsr_en_d;
    end
  end

  assign state    = state_q;
  assign react_ms = react_q;
  assign hi_score = hi_q;
  assign new_hi   = new_hi_q;
  assign cheat    = cheat_q;
  assign lfsr_en  = lfsr_en_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Scoreboard bench for reaction_ctrl: expected state entries are queued
// by the stimulus and compared by a monitor on every state change.
module tb_reaction_ctrl;
  import reaction_pkg::*;

  localparam int MIN_D = 1000;
  localparam int MAX_T = 9999;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick_1ms;
  logic        start_n;
  logic        react_n;
  logic        buffs_sw;
  logic [9:0]  rand_delay;
  logic        lfsr_en;
  logic [2:0]  state;
  logic [13:0] react_ms;
  logic [13:0] hi_score;
  logic        new_hi;
  logic        cheat;

  always #10 clk = ~clk;

  reaction_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1ms   (tick_1ms),
    .start_n    (start_n),
    .react_n    (react_n),
    .buffs_sw   (buffs_sw),
    .rand_delay (rand_delay),
    .lfsr_en    (lfsr_en),
    .state      (state),
    .react_ms   (react_ms),
    .hi_score   (hi_score),
    .new_hi     (new_hi),
    .cheat      (cheat)
  );

  typedef struct {
    logic [2:0] st;
    int         ms;
    int         hi;
    bit         ch;
    bit         nh;
  } exp_t;

  exp_t       exp_q[$];
  int         n_pass  = 0;
  int         n_total = 0;
  bit         mon_en  = 1'b0;
  logic [2:0] prev_st;

  // reference model: best valid time, last shown time and cheat flag
  int m_hi    = MAX_T;
  int m_react = 0;
  bit m_cheat = 1'b0;

  task automatic check(string name, bit ok, string got, string want);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s required %s", name, got, want);
  endtask

  function automatic void expect_st(logic [2:0] st, int ms, bit ch);
    exp_t e;
    m_react = ms;
    m_cheat = ch;
    e = '{st: st, ms: ms, hi: m_hi, ch: ch, nh: 1'b0};
    exp_q.push_back(e);
  endfunction

  function automatic void expect_disp(int t, bit ch);
    exp_t e;
    int   r;
    bit   nh;
    r  = ch ? MAX_T : (t > MAX_T ? MAX_T : t);
    nh = !ch && (r < m_hi);
    if (nh) m_hi = r;
    m_react = r;
    m_cheat = ch;
    e = '{st: 3'd3, ms: r, hi: m_hi, ch: ch, nh: nh};
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    bit   lf;
    if (mon_en) begin
      if (state !== prev_st) begin
        if (exp_q.size() == 0) begin
          check("unexpected_transition", 1'b0,
                $sformatf("st=%0d", state), "no change");
        end else begin
          e  = exp_q.pop_front();
          lf = (e.st == 3'd0) || (e.st == 3'd3);
          ok = (state === e.st) && (int'(react_ms) == e.ms) &&
               (int'(hi_score) == e.hi) && (cheat === e.ch) &&
               (new_hi === e.nh) && (lfsr_en === lf);
          check($sformatf("enter_st%0d", e.st), ok,
                $sformatf("st=%0d ms=%0d hi=%0d ch=%0b nh=%0b lf=%0b",
                          state, react_ms, hi_score, cheat, new_hi, lfsr_en),
                $sformatf("st=%0d ms=%0d hi=%0d ch=%0b nh=%0b lf=%0b",
                          e.st, e.ms, e.hi, e.ch, e.nh, lf));
        end
      end else if (new_hi !== 1'b0) begin
        check("new_hi_pulse", 1'b0, $sformatf("%b", new_hi), "0");
      end
    end
    prev_st = state;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      tick_1ms = 1'b1;
      step();
      tick_1ms = 1'b0;
      step();
    end
  endtask

  task automatic press_start();
    start_n = 1'b0;
    repeat (6) step();
    start_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic press_react();
    react_n = 1'b0;
    repeat (6) step();
    react_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic press_both();
    start_n = 1'b0;
    react_n = 1'b0;
    repeat (6) step();
    start_n = 1'b1;
    react_n = 1'b1;
    repeat (4) step();
  endtask

  // key falls, two sync stages later the pulse meets a tick on one edge
  task automatic press_react_on_tick();
    react_n = 1'b0;
    step();
    step();
    tick_1ms = 1'b1;
    step();
    tick_1ms = 1'b0;
    repeat (4) step();
    react_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic wait_for(logic [2:0] st, string name);
    for (int i = 0; i < 20 && state !== st; i++) step();
    check(name, state === st, $sformatf("st=%0d", state),
          $sformatf("st=%0d", st));
  endtask

  // mode 0 press, 1 press on tick, 2 cheat after n ticks, 3 timeout
  task automatic run_round(int r, int n, int mode);
    rand_delay = 10'(r);
    expect_st(3'd1, 0, 1'b0);
    press_start();
    wait_for(3'd1, "to_delaying");
    if (mode == 2) begin
      ticks(n);
      expect_disp(0, 1'b1);
      press_react();
    end else begin
      ticks(MIN_D + r - 1);
      expect_st(3'd2, 0, 1'b0);
      ticks(1);
      wait_for(3'd2, "to_timing");
      if (mode == 3) begin
        ticks(MAX_T - 1);
        expect_disp(MAX_T, 1'b0);
        ticks(1);
      end else begin
        ticks(n);
        expect_disp(n, 1'b0);
        if (mode == 1) press_react_on_tick();
        else press_react();
      end
    end
    wait_for(3'd3, "to_displaying");
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int n;
    int mode;
    rst_n      = 1'b0;
    tick_1ms   = 1'b0;
    start_n    = 1'b1;
    react_n    = 1'b1;
    buffs_sw   = 1'b0;
    rand_delay = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_state", state === 3'd0, $sformatf("%0d", state), "0");
    check("rst_react", react_ms === 14'd0, $sformatf("%0d", react_ms), "0");
    check("rst_hi", int'(hi_score) == MAX_T,
          $sformatf("%0d", hi_score), $sformatf("%0d", MAX_T));
    check("rst_new_hi", new_hi === 1'b0, $sformatf("%b", new_hi), "0");
    check("rst_cheat", cheat === 1'b0, $sformatf("%b", cheat), "0");
    check("rst_lfsr_en", lfsr_en === 1'b1, $sformatf("%b", lfsr_en), "1");
    mon_en = 1'b1;

    run_round(0, 250, 0);
    run_round(int'($urandom_range(0, 1023)), 100, 2);

    expect_st(3'd0, m_react, m_cheat);
    press_both();
    wait_for(3'd0, "both_keys");
    press_react();
    check("react_ignored", state === 3'd0, $sformatf("%0d", state), "0");

    run_round(0, 0, 3);
    ticks(5);
    check("timeout_hold", int'(react_ms) == MAX_T && state === 3'd3,
          $sformatf("ms=%0d st=%0d", react_ms, state),
          $sformatf("ms=%0d st=3", MAX_T));

    rand_delay = 10'd5;
    expect_st(3'd1, 0, 1'b0);
    press_start();
    wait_for(3'd1, "rst_round_delaying");
    ticks(MIN_D + 4);
    expect_st(3'd2, 0, 1'b0);
    ticks(1);
    wait_for(3'd2, "rst_round_timing");
    ticks(20);
    m_hi = MAX_T;
    expect_st(3'd0, 0, 1'b0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    wait_for(3'd0, "mid_round_reset");

    run_round(int'($urandom_range(0, 1023)), 300, 1);
    run_round(int'($urandom_range(0, 1023)), 300, 1);

    rand_delay = 10'd0;
    expect_st(3'd1, 0, 1'b0);
    press_start();
    wait_for(3'd1, "buffs_delaying");
    ticks(MIN_D - 1);
    expect_st(3'd2, 0, 1'b0);
    ticks(1);
    wait_for(3'd2, "buffs_timing");
    ticks(40);
    expect_st(3'd4, 40, 1'b0);
    buffs_sw = 1'b1;
    step();
    check("buffs_next_clk", state === 3'd4, $sformatf("%0d", state), "4");
    press_start();
    press_react();
    expect_st(3'd0, 40, 1'b0);
    buffs_sw = 1'b0;
    step();
    wait_for(3'd0, "buffs_release");

    for (int k = 0; k < 4; k++) begin
      r    = int'($urandom_range(0, 1023));
      mode = int'($urandom_range(0, 2));
      n    = (mode == 2) ? int'($urandom_range(0, 999))
                         : int'($urandom_range(1, 600));
      run_round(r, n, mode);
    end
    expect_st(3'd0, m_react, m_cheat);
    press_react();
    wait_for(3'd0, "final_hi_score");
    repeat (4) step();

    check("queue_empty", exp_q.size() == 0,
          $sformatf("%0d left", exp_q.size()), "0 left");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reaction_ctrl.md
REACTION_CTRL -- requirements
Module: reaction_ctrl

Interface
REQ-001 SHALL have parameter MIN_DELAY_MS, default 1000, meaning the fixed part of the pre-stimulus delay in ms.
REQ-002 SHALL have parameter MAX_MS, default 9999, meaning the saturation and timeout value for reaction time in ms.
REQ-003 SHALL have port clk, input, 1, the single system clock (50 MHz); all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port tick_1ms, input, 1, one-clk-wide strobe at 1 kHz.
REQ-006 SHALL have port start_n, input, 1, active-low start key, asynchronous to clk.
REQ-007 SHALL have port react_n, input, 1, active-low react key, asynchronous to clk.
REQ-008 SHALL have port buffs_sw, input, 1, level override that forces the GO_BUFFS display.
REQ-009 SHALL have port rand_delay, input, 10, the LFSR value sampled when a round starts.
REQ-010 SHALL have port lfsr_en, output, 1, LFSR advance enable.
REQ-011 SHALL have port state, output, 3, the current state encoding.
REQ-012 SHALL have port react_ms, output, 14, the last or running reaction time.
REQ-013 SHALL have port hi_score, output, 14, the best valid reaction time.
REQ-014 SHALL have port new_hi, output, 1, a one-clk pulse on a high-score update.
REQ-015 SHALL have port cheat, output, 1, set when react is pressed during the delay.

Function
REQ-016 SHALL pass start_n and react_n each through a 2-flop synchronizer, then a falling-edge detector, giving one-clk press pulses start_p and react_p.
REQ-017 SHALL use these state encodings: HI_SCORE=000, DELAYING=001, TIMING=010, DISPLAYING=011, GO_BUFFS=100.
REQ-018 SHALL give buffs_sw=1 highest priority: next state is GO_BUFFS from any state, and the delay counter is cleared.
REQ-019 SHALL, in GO_BUFFS, go to HI_SCORE on the first clk with buffs_sw=0; hi_score is retained.
REQ-020 SHALL, in HI_SCORE, go to DELAYING on start_p, load delay_cnt = MIN_DELAY_MS + rand_delay (1000..2023), and clear react_ms and cheat.
REQ-021 SHALL, in DELAYING, decrement delay_cnt on each tick_1ms; when delay_cnt==1 and a tick occurs, go to TIMING with react_ms=0.
REQ-022 SHALL, in DELAYING, treat react_p as a cheat: go to DISPLAYING, set react_ms=MAX_MS and cheat=1; react_p wins over a simultaneous tick.
REQ-023 SHALL, in TIMING, increment react_ms on each tick_1ms.
REQ-024 SHALL, in TIMING, go to DISPLAYING on react_p; if react_p and a tick occur in the same clk, react_ms is not incremented.
REQ-025 SHALL, in TIMING, go to DISPLAYING as a timeout when react_ms reaches MAX_MS; react_ms saturates and never wraps.
REQ-026 SHALL, on the first clk in DISPLAYING, update hi_score if cheat==0 and react_ms < hi_score: hi_score <= react_ms and new_hi pulses for exactly 1 clk.
REQ-027 SHALL leave hi_score unchanged when react_ms equals hi_score.
REQ-028 SHALL, in DISPLAYING, go to HI_SCORE on react_p, else to DELAYING on start_p (same load as REQ-020); react_p wins if both pulse in the same clk.
REQ-029 SHALL ignore start_p in DELAYING, TIMING and GO_BUFFS, and ignore react_p in HI_SCORE and GO_BUFFS.
REQ-030 SHALL drive lfsr_en=1 in HI_SCORE and DISPLAYING, and 0 in all other states.
REQ-031 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-032 SHALL, on a clk edge with rst_n=0, set state=HI_SCORE, react_ms=0, hi_score=MAX_MS, new_hi=0, cheat=0, delay_cnt=0, lfsr_en=1, and synchronizer flops to 1 (key released).
REQ-033 SHALL let reset mid-round abort the round with no high-score update; reset takes priority over buffs_sw.

Structure
REQ-034 SHALL place the state encodings, MIN_DELAY_MS and MAX_MS defaults, and the width constants (14-bit time, 10-bit random value) in shared package reaction_pkg.
REQ-035 SHALL implement the synchronizer plus edge detector as sub-module key_edge, instantiated twice; the FSM and datapath registers are in reaction_ctrl.

Verification
REQ-036 SHALL cover: reset, then start press with rand_delay=0 -> DELAYING, TIMING entered after exactly 1000 ticks, react_ms=0.
REQ-037 SHALL cover: in TIMING, react press after 250 ticks -> DISPLAYING, react_ms=250, hi_score=250, new_hi high for 1 clk.
REQ-038 SHALL cover: react press 100 ticks into DELAYING -> DISPLAYING, cheat=1, react_ms=9999, hi_score unchanged, no new_hi pulse.
REQ-039 SHALL cover: no press in TIMING -> DISPLAYING at react_ms=9999, no wrap, hi_score unchanged.
REQ-040 SHALL cover: react_p coincident with a tick at react_ms=300 -> react_ms=300; a second round at 300 gives no new_hi.
REQ-041 SHALL cover: buffs_sw=1 mid-TIMING -> state=100 on the next clk; buffs_sw=0 -> HI_SCORE with hi_score retained.
